lvt_port_controller: RTL and testbench
======================================

// Module: lvt_port_controller
// PURPOSE
//  Live-value-table controller for the 4-port multiported data cache.
//  Records which accelerator port last wrote each cache word index.
//  On each read, returns a registered bank selector that drives the per-read-port
//  word muxes (3-to-1, ACCEL_2/ACCEL_3 share bank 2).
//  Also resolves same-cycle write conflicts and runs the post-reset table clear.
// PARAMETERS
//  IDX_W    9   word-index width; table depth = 2**IDX_W
//  NPORTS   4   accelerator ports (fixed; selector encodings from `ACCEL_0..3)
//  SEL_W    2   LVT entry width, equals width of `LVT_ENTRY
// PORTS
//  clk           in   1         system clock
//  reset         in   1         synchronous, active-high
//  ready         out  1         table initialised, accepting requests
//  wr_en_N       in   1         N=0..3: port N writes its bank this cycle
//  wr_idx_N      in   IDX_W     N=0..3: word index written by port N
//  wr_drop_N     out  1         N=0..3: pulse, port N's LVT update lost a same-index conflict
//  rd_en_N       in   1         N=0..3: read lookup request
//  rd_idx_N      in   IDX_W     N=0..3: word index to look up
//  sel_N         out  SEL_W     N=0..3: `LVT_ENTRY selector for read port N's mux
//  sel_valid_N   out  1         N=0..3: sel_N valid (1 cycle after rd_en_N)
// BEHAVIOUR
//  Reset values: ready=0, sel_N=`ACCEL_0, sel_valid_N=0, wr_drop_N=0, state=INIT,
//   clear pointer=0. Reset asserted mid-operation restarts INIT; table contents are not trusted.
//  State machine:
//   INIT: each cycle writes entry[ptr]=`ACCEL_0 and increments ptr.
//    At ptr==2**IDX_W-1, the final entry is written and state goes to RUN next cycle.
//    INIT lasts exactly 2**IDX_W cycles after reset deassert.
//    ready=0; wr_en/rd_en are ignored (no drop, no valid).
//   RUN: ready=1; no exit except reset.
//  Write update (RUN): for each asserted wr_en_N, entry[wr_idx_N] <= `ACCEL_N at clk edge.
//   Same-index conflict: lowest port index wins.
//   Losing ports assert wr_drop_N for exactly one cycle (registered, same edge as the table write).
//   Distinct indices: all ports update in the same cycle.
//  Read lookup (RUN): rd_en_N at cycle t -> sel_N and sel_valid_N=1 at cycle t+1.
//   Latency is fixed at 1 with no stall.
//   When rd_en_N=0: sel_valid_N=0 and sel_N holds its last value.
//  Read-during-write, same index, same cycle: read returns the OLD entry, matching bank RAM
//   old-data read behaviour. A write at t is visible to a read issued at t+1.
//  All four read ports are independent. Any combination of indices, including all equal, is legal.
//  Outputs are registered only; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared defines stay in cache_parameters.v:
//   `LVT_ENTRY, `WORD, `ACCEL_0..`ACCEL_3, and a new `LVT_IDX (IDX_W-1:0).
//  Table: flop array of 2**IDX_W x SEL_W with 4 write ports and 4 read ports (not a RAM macro).
//  Sub-module lvt_write_resolve (combinational):
//   takes wr_en_N and wr_idx_N;
//   produces per-port effective write enables and drop flags (lowest-index-wins).
//  INIT/RUN FSM and clear pointer live in the top module.
// TESTING
//  1. Reset, then count cycles -> ready rises exactly 2**IDX_W cycles after reset deassert.
//     Reads of idx 0, 5 and max afterwards -> sel=`ACCEL_0.
//  2. wr_en_2 idx=0x10 at t; rd_en_0 idx=0x10 at t and at t+1
//     -> sel_0=`ACCEL_0 at t+1, sel_0=`ACCEL_2 at t+2.
//  3. wr_en_1 and wr_en_3 both idx=0x20 -> entry=`ACCEL_1; wr_drop_3=1 for one cycle; wr_drop_1=0.
//  4. All 4 ports write distinct idx 1..4 in one cycle; all 4 ports read idx 4,3,2,1 next cycle
//     -> sel_0..3 = `ACCEL_3, `ACCEL_2, `ACCEL_1, `ACCEL_0.
//  5. Write idx 0x30 from port 2, then assert reset mid-RUN
//     -> ready=0, sel_valid=0; after re-init, read 0x30 -> `ACCEL_0.
//  6. rd_en/wr_en pulses during INIT -> no sel_valid, no wr_drop, table unchanged after INIT.

Source files
------------

// File: rtl/lvt_port_controller_pkg.sv
// rtl/lvt_port_controller_pkg.sv - shared widths, selector encodings and FSM states for the LVT controller
package lvt_port_controller_pkg;

  localparam int IDX_W  = 9;   // word-index width; table depth = 2**IDX_W
  localparam int NPORTS = 4;   // accelerator ports
  localparam int SEL_W  = 2;   // LVT entry width

  typedef logic [SEL_W-1:0] lvt_entry_t;
  typedef logic [IDX_W-1:0] lvt_idx_t;

  // Selector encodings; the read mux folds ACCEL_2 and ACCEL_3 onto bank 2.
  localparam lvt_entry_t ACCEL_0 = 2'd0;
  localparam lvt_entry_t ACCEL_1 = 2'd1;
  localparam lvt_entry_t ACCEL_2 = 2'd2;
  localparam lvt_entry_t ACCEL_3 = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lvt_state_t;

  // Selector that a write from accelerator port n stores in the table.
  function automatic lvt_entry_t accel_sel(input int n);
    return lvt_entry_t'(n);
  endfunction

endpackage

// File: rtl/lvt_port_controller_if.sv
// rtl/lvt_port_controller_if.sv - write/read request bundle between cache ports and the LVT controller
// Signals (N=0..3):
//   ready        controller -> ports  table initialised
//   wr_en_N      ports -> controller  port N writes its bank
//   wr_idx_N     ports -> controller  word index written by port N
//   wr_drop_N    controller -> ports  port N's update lost a same-index conflict
//   rd_en_N      ports -> controller  read lookup request
//   rd_idx_N     ports -> controller  word index to look up
//   sel_N        controller -> ports  bank selector for read port N
//   sel_valid_N  controller -> ports  sel_N valid, one cycle after rd_en_N
interface lvt_port_controller_if;
  import lvt_port_controller_pkg::*;

  logic       ready;
  logic       wr_en_0, wr_en_1, wr_en_2, wr_en_3;
  lvt_idx_t   wr_idx_0, wr_idx_1, wr_idx_2, wr_idx_3;
  logic       wr_drop_0, wr_drop_1, wr_drop_2, wr_drop_3;
  logic       rd_en_0, rd_en_1, rd_en_2, rd_en_3;
  lvt_idx_t   rd_idx_0, rd_idx_1, rd_idx_2, rd_idx_3;
  lvt_entry_t sel_0, sel_1, sel_2, sel_3;
  logic       sel_valid_0, sel_valid_1, sel_valid_2, sel_valid_3;

  modport master (
    input  ready,
    output wr_en_0, wr_en_1, wr_en_2, wr_en_3,
    output wr_idx_0, wr_idx_1, wr_idx_2, wr_idx_3,
    input  wr_drop_0, wr_drop_1, wr_drop_2, wr_drop_3,
    output rd_en_0, rd_en_1, rd_en_2, rd_en_3,
    output rd_idx_0, rd_idx_1, rd_idx_2, rd_idx_3,
    input  sel_0, sel_1, sel_2, sel_3,
    input  sel_valid_0, sel_valid_1, sel_valid_2, sel_valid_3
  );

  modport slave (
    output ready,
    input  wr_en_0, wr_en_1, wr_en_2, wr_en_3,
    input  wr_idx_0, wr_idx_1, wr_idx_2, wr_idx_3,
    output wr_drop_0, wr_drop_1, wr_drop_2, wr_drop_3,
    input  rd_en_0, rd_en_1, rd_en_2, rd_en_3,
    input  rd_idx_0, rd_idx_1, rd_idx_2, rd_idx_3,
    output sel_0, sel_1, sel_2, sel_3,
    output sel_valid_0, sel_valid_1, sel_valid_2, sel_valid_3
  );

endinterface

// File: rtl/lvt_write_resolve.sv
// rtl/lvt_write_resolve.sv - combinational same-index write conflict resolution, lowest port wins
// Ports:
//   wr_en    in   per-port write requests
//   wr_idx   in   per-port word indices
//   wr_eff   out  per-port effective table write enables
//   wr_drop  out  per-port flag: request lost to a lower-numbered port
module lvt_write_resolve
  import lvt_port_controller_pkg::*;
(
  input  logic [NPORTS-1:0]            wr_en,
  input  logic [NPORTS-1:0][IDX_W-1:0] wr_idx,
  output logic [NPORTS-1:0]            wr_eff,
  output logic [NPORTS-1:0]            wr_drop
);

  always_comb begin
    wr_eff  = wr_en;
    wr_drop = '0;
    for (int n = 1; n < NPORTS; n++) begin
      for (int j = 0; j < n; j++) begin
        if (wr_en[n] && wr_en[j] && (wr_idx[j] == wr_idx[n])) begin
          wr_eff[n]  = 1'b0;
          wr_drop[n] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lvt_port_controller.sv
// rtl/lvt_port_controller.sv - live-value table: tracks last writer per word, returns registered bank selectors
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; restarts the table clear
//   bus    slave modport of lvt_port_controller_if (ready, 4 write ports, 4 read ports)
module lvt_port_controller
  import lvt_port_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  lvt_port_controller_if.slave  bus
);

  localparam int DEPTH = 2 ** IDX_W;

  lvt_state_t state_q, state_d;
  lvt_idx_t   ptr_q, ptr_d;
  logic       run;

  lvt_entry_t table_q [DEPTH];

  logic [NPORTS-1:0]            wr_en, rd_en, wr_eff, wr_drop;
  logic [NPORTS-1:0][IDX_W-1:0] wr_idx, rd_idx;

  lvt_entry_t        sel_q [NPORTS];
  logic [NPORTS-1:0] sel_valid_q, wr_drop_q;

  assign wr_en  = {bus.wr_en_3, bus.wr_en_2, bus.wr_en_1, bus.wr_en_0};
  assign wr_idx = {bus.wr_idx_3, bus.wr_idx_2, bus.wr_idx_1, bus.wr_idx_0};
  assign rd_en  = {bus.rd_en_3, bus.rd_en_2, bus.rd_en_1, bus.rd_en_0};
  assign rd_idx = {bus.rd_idx_3, bus.rd_idx_2, bus.rd_idx_1, bus.rd_idx_0};

  lvt_write_resolve u_resolve (
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_eff  (wr_eff),
    .wr_drop (wr_drop)
  );

  // INIT walks the clear pointer over every entry once, then RUN holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == lvt_idx_t'(DEPTH - 1))
          state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign run = (state_q == ST_RUN);

  // Table is not reset: contents are only trusted after the INIT sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        table_q[ptr_q] <= ACCEL_0;
      end else begin
        for (int n = 0; n < NPORTS; n++)
          if (wr_eff[n])
            table_q[wr_idx[n]] <= accel_sel(n);
      end
    end
  end

  // Lookups sample the pre-edge table, so a same-cycle write is seen only by the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_valid_q <= '0;
      wr_drop_q   <= '0;
      for (int n = 0; n < NPORTS; n++)
        sel_q[n] <= ACCEL_0;
    end else begin
      sel_valid_q <= run ? rd_en : '0;
      wr_drop_q   <= run ? wr_drop : '0;
      for (int n = 0; n < NPORTS; n++)
        if (run && rd_en[n])
          sel_q[n] <= table_q[rd_idx[n]];
    end
  end

  assign bus.ready       = run;
  assign bus.sel_0       = sel_q[0];
  assign bus.sel_1       = sel_q[1];
  assign bus.sel_2       = sel_q[2];
  assign bus.sel_3       = sel_q[3];
  assign bus.sel_valid_0 = sel_valid_q[0];
  assign bus.sel_valid_1 = sel_valid_q[1];
  assign bus.sel_valid_2 = sel_valid_q[2];
  assign bus.sel_valid_3 = sel_valid_q[3];
  assign bus.wr_drop_0   = wr_drop_q[0];
  assign bus.wr_drop_1   = wr_drop_q[1];
  assign bus.wr_drop_2   = wr_drop_q[2];
  assign bus.wr_drop_3   = wr_drop_q[3];

endmodule

// File: tb/tb_lvt_port_controller.sv
// tb/tb_lvt_port_controller.sv - directed self-checking bench for lvt_port_controller
module tb_lvt_port_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lvt_port_controller_if bus ();

  lvt_port_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en_0 = 0; bus.wr_en_1 = 0; bus.wr_en_2 = 0; bus.wr_en_3 = 0;
    bus.rd_en_0 = 0; bus.rd_en_1 = 0; bus.rd_en_2 = 0; bus.rd_en_3 = 0;
    bus.wr_idx_0 = '0; bus.wr_idx_1 = '0; bus.wr_idx_2 = '0; bus.wr_idx_3 = '0;
    bus.rd_idx_0 = '0; bus.rd_idx_1 = '0; bus.rd_idx_2 = '0; bus.rd_idx_3 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic any_valid_or_drop();
    return bus.sel_valid_0 | bus.sel_valid_1 | bus.sel_valid_2 | bus.sel_valid_3 |
           bus.wr_drop_0 | bus.wr_drop_1 | bus.wr_drop_2 | bus.wr_drop_3;
  endfunction

  // Called at a negedge right after reset is dropped; pokes writes/reads late in INIT
  // (idx 5 is already cleared by then) and counts edges until ready rises.
  task automatic run_init(input string tag);
    int   cyc;
    logic seen_bad;
    cyc = 0;
    seen_bad = 1'b0;
    while (!bus.ready && cyc < 2000) begin
      if (cyc == 300) begin
        bus.wr_en_1 = 1; bus.wr_idx_1 = 9'd5;
        bus.wr_en_3 = 1; bus.wr_idx_3 = 9'd5;
        bus.rd_en_0 = 1; bus.rd_idx_0 = 9'd5;
        bus.rd_en_2 = 1; bus.rd_idx_2 = 9'd5;
      end
      if (cyc == 302) idle();
      step();
      cyc++;
      if (any_valid_or_drop()) seen_bad = 1'b1;
    end
    idle();
    check({tag, "_cycles"}, cyc, 512);
    check({tag, "_quiet"}, 32'(seen_bad), 0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_ready", 32'(bus.ready), 0);
    check("rst_valid_drop", 32'(any_valid_or_drop()), 0);
    check("rst_sel", 32'({bus.sel_0, bus.sel_1, bus.sel_2, bus.sel_3}), 0);
    reset = 1'b0;

    // 1 + 6: init length, INIT ignores requests, cleared entries read ACCEL_0
    run_init("init1");
    bus.rd_en_0 = 1; bus.rd_idx_0 = 9'd0;
    bus.rd_en_1 = 1; bus.rd_idx_1 = 9'd5;
    bus.rd_en_2 = 1; bus.rd_idx_2 = 9'h1ff;
    step();
    idle();
    check("t1_valid", 32'({bus.sel_valid_0, bus.sel_valid_1, bus.sel_valid_2, bus.sel_valid_3}), 32'b1110);
    check("t1_sel0", 32'(bus.sel_0), 0);
    check("t1_sel5", 32'(bus.sel_1), 0);
    check("t1_selmax", 32'(bus.sel_2), 0);

    // 2: read-during-write returns old entry, next-cycle read sees new one
    bus.wr_en_2 = 1; bus.wr_idx_2 = 9'h10;
    bus.rd_en_0 = 1; bus.rd_idx_0 = 9'h10;
    step();
    check("t2_rdw_valid", 32'(bus.sel_valid_0), 1);
    check("t2_rdw_old", 32'(bus.sel_0), 0);
    bus.wr_en_2 = 0;
    step();
    check("t2_new", 32'(bus.sel_0), 2);
    bus.rd_en_0 = 0;
    step();
    check("t2_idle_valid", 32'(bus.sel_valid_0), 0);
    check("t2_idle_hold", 32'(bus.sel_0), 2);

    // 3: same-index conflict between ports 1 and 3
    bus.wr_en_1 = 1; bus.wr_idx_1 = 9'h20;
    bus.wr_en_3 = 1; bus.wr_idx_3 = 9'h20;
    step();
    idle();
    check("t3_drop3", 32'(bus.wr_drop_3), 1);
    check("t3_drop1", 32'(bus.wr_drop_1), 0);
    bus.rd_en_1 = 1; bus.rd_idx_1 = 9'h20;
    step();
    idle();
    check("t3_drop3_pulse", 32'(bus.wr_drop_3), 0);
    check("t3_entry", 32'(bus.sel_1), 1);

    // 4: four distinct writes in one cycle, crossed reads next cycle
    bus.wr_en_0 = 1; bus.wr_idx_0 = 9'd1;
    bus.wr_en_1 = 1; bus.wr_idx_1 = 9'd2;
    bus.wr_en_2 = 1; bus.wr_idx_2 = 9'd3;
    bus.wr_en_3 = 1; bus.wr_idx_3 = 9'd4;
    step();
    idle();
    check("t4_no_drop", 32'({bus.wr_drop_0, bus.wr_drop_1, bus.wr_drop_2, bus.wr_drop_3}), 0);
    bus.rd_en_0 = 1; bus.rd_idx_0 = 9'd4;
    bus.rd_en_1 = 1; bus.rd_idx_1 = 9'd3;
    bus.rd_en_2 = 1; bus.rd_idx_2 = 9'd2;
    bus.rd_en_3 = 1; bus.rd_idx_3 = 9'd1;
    step();
    check("t4_sel0", 32'(bus.sel_0), 3);
    check("t4_sel1", 32'(bus.sel_1), 2);
    check("t4_sel2", 32'(bus.sel_2), 1);
    check("t4_sel3", 32'(bus.sel_3), 0);
    // all four ports on one index
    bus.rd_idx_0 = 9'h10; bus.rd_idx_1 = 9'h10; bus.rd_idx_2 = 9'h10; bus.rd_idx_3 = 9'h10;
    step();
    idle();
    check("t4_same_idx", 32'({bus.sel_0, bus.sel_1, bus.sel_2, bus.sel_3}), 32'b10101010);

    // 5: reset mid-RUN clears table
    bus.wr_en_2 = 1; bus.wr_idx_2 = 9'h30;
    step();
    idle();
    bus.rd_en_3 = 1; bus.rd_idx_3 = 9'h30;
    step();
    idle();
    check("t5_written", 32'(bus.sel_3), 2);
    bus.rd_en_3 = 1; bus.rd_idx_3 = 9'h30;
    reset = 1'b1;
    step();
    idle();
    check("t5_rst_ready", 32'(bus.ready), 0);
    check("t5_rst_valid", 32'(bus.sel_valid_3), 0);
    reset = 1'b0;
    run_init("init2");
    bus.rd_en_3 = 1; bus.rd_idx_3 = 9'h30;
    bus.rd_en_0 = 1; bus.rd_idx_0 = 9'd5;
    step();
    idle();
    check("t5_cleared", 32'(bus.sel_3), 0);
    check("t6_idx5_unchanged", 32'(bus.sel_0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
